// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Requester, memory-side and status signals of the two-port
//                data-memory arbiter, with arbiter (slave) and driver (master)
//                views.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [31:0] addr0;
   logic [31:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic [3:0]  mask0;
   logic [3:0]  mask1;
   logic        ack0;
   logic        ack1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;

   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_sign_mask;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [31:0] mem_read_data;
   logic        mem_stall;

   logic        busy;
   logic        grant_id;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
      output ack0, ack1, rdata0, rdata1,
      output mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
      input  mem_read_data, mem_stall,
      output busy, grant_id
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
      input  ack0, ack1, rdata0, rdata1,
      input  mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
      output mem_read_data, mem_stall,
      input  busy, grant_id
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one data-memory port between two masters, one access
//                at a time. Define DMEM_ARB_RR_EN for round-robin ties,
//                otherwise port 0 has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int MIN_LAT = 3
) (
   input  wire logic     clk,
   input  wire logic     reset_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] c_EXIT_CNT = 4'(MIN_LAT - 1);

   state_t      r_state,    w_state_nxt;
   logic [3:0]  r_cnt,      w_cnt_nxt;
   logic        r_grant,    w_grant_nxt;
   logic        r_last,     w_last_nxt;
   logic        r_we,       w_we_nxt;
   logic [31:0] r_addr,     w_addr_nxt;
   logic [31:0] r_wdata,    w_wdata_nxt;
   logic [3:0]  r_mask,     w_mask_nxt;
   logic        r_memread,  w_memread_nxt;
   logic        r_memwrite, w_memwrite_nxt;
   logic        r_ack0,     w_ack0_nxt;
   logic        r_ack1,     w_ack1_nxt;
   logic [31:0] r_rdata0,   w_rdata0_nxt;
   logic [31:0] r_rdata1,   w_rdata1_nxt;
   logic        r_busy,     w_busy_nxt;

   logic        w_win;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [3:0]  w_sel_mask;

`ifdef DMEM_ARB_RR_EN
   assign w_win = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
`else
   assign w_win = ~bus.req0 & bus.req1;
`endif

   assign w_sel_we    = w_win ? bus.we1    : bus.we0;
   assign w_sel_addr  = w_win ? bus.addr1  : bus.addr0;
   assign w_sel_wdata = w_win ? bus.wdata1 : bus.wdata0;
   assign w_sel_mask  = w_win ? bus.mask1  : bus.mask0;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_grant_nxt    = r_grant;
      w_last_nxt     = r_last;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_mask_nxt     = r_mask;
      w_rdata0_nxt   = r_rdata0;
      w_rdata1_nxt   = r_rdata1;
      w_memread_nxt  = 1'b0;
      w_memwrite_nxt = 1'b0;
      w_ack0_nxt     = 1'b0;
      w_ack1_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               w_state_nxt    = S_ISSUE;
               w_grant_nxt    = w_win;
               w_we_nxt       = w_sel_we;
               w_addr_nxt     = w_sel_addr;
               w_wdata_nxt    = w_sel_wdata;
               w_mask_nxt     = w_sel_mask;
               w_memread_nxt  = ~w_sel_we;
               w_memwrite_nxt = w_sel_we;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'd0;
         end
         S_WAIT: begin
            // Stall is only looked at once the minimum latency has elapsed
            if ((r_cnt >= c_EXIT_CNT) && !bus.mem_stall) begin
               w_state_nxt = S_DONE;
               if (!r_we) begin
                  if (r_grant) w_rdata1_nxt = bus.mem_read_data;
                  else         w_rdata0_nxt = bus.mem_read_data;
               end
               w_ack0_nxt = ~r_grant;
               w_ack1_nxt = r_grant;
            end else if (r_cnt != 4'hF) begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_DONE: begin
            // Requests are ignored here so a req dropping with the ack never re-issues
            w_state_nxt = S_IDLE;
            w_last_nxt  = r_grant;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_grant    <= 1'b0;
         r_last     <= 1'b1;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_mask     <= 4'd0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_rdata0   <= 32'd0;
         r_rdata1   <= 32'd0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_grant    <= w_grant_nxt;
         r_last     <= w_last_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_mask     <= w_mask_nxt;
         r_memread  <= w_memread_nxt;
         r_memwrite <= w_memwrite_nxt;
         r_ack0     <= w_ack0_nxt;
         r_ack1     <= w_ack1_nxt;
         r_rdata0   <= w_rdata0_nxt;
         r_rdata1   <= w_rdata1_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign bus.ack0           = r_ack0;
   assign bus.ack1           = r_ack1;
   assign bus.rdata0         = r_rdata0;
   assign bus.rdata1         = r_rdata1;
   assign bus.mem_addr       = r_addr;
   assign bus.mem_write_data = r_wdata;
   assign bus.mem_sign_mask  = r_mask;
   assign bus.mem_memread    = r_memread;
   assign bus.mem_memwrite   = r_memwrite;
   assign bus.busy           = r_busy;
   assign bus.grant_id       = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed vector table,
//                corner sequences and a randomized transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam int MIN_LAT = 3;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter_if busm ();

   dmem_arbiter #(.MIN_LAT(MIN_LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   dmem_arbiter #(.MIN_LAT(1)) dut_m (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busm)
   );

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] mdata;
      int          stall_lo;
      int          stall_hi;
      int          exp_ack;
   } vec_t;

   typedef struct {
      int          ack_cyc;
      int          rd_n;
      int          wr_n;
      int          strobe_cyc;
      logic [31:0] s_addr;
      logic [31:0] s_wdata;
      logic [3:0]  s_mask;
      bit          addr_ok;
      bit          other_ack;
   } res_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_rd [2];
   vec_t        vecs [6];
   res_t        res;

   // Randomized-phase model state
   bit          act;
   bit          a_port, a_we;
   logic [31:0] a_addr, a_wdata;
   logic [3:0]  a_mask;
   int          a_t, a_ack;
   bit          m_last;
   bit          pend [2];
   bit          p_we [2];
   logic [31:0] p_addr [2], p_wdata [2];
   logic [3:0]  p_mask [2];
   bit          in_acc, stall_now, win;
   logic [31:0] rd_now;
   logic [4:0]  exp_ctrl;

   int          gseq [5];
   int          exp_seq [5];
   int          nack;
   int          acks_m [3];

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      bus.mask0 = 0; bus.mask1 = 0; bus.mem_read_data = 0; bus.mem_stall = 0;
      busm.req0 = 0; busm.req1 = 0; busm.we0 = 0; busm.we1 = 0;
      busm.addr0 = 0; busm.addr1 = 0; busm.wdata0 = 0; busm.wdata1 = 0;
      busm.mask0 = 0; busm.mask1 = 0; busm.mem_read_data = 0; busm.mem_stall = 0;
   endtask

   task automatic drive_port(input bit p, input bit r, input bit we,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m);
      if (!p) begin
         bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.mask0 = m;
      end else begin
         bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.mask1 = m;
      end
   endtask

   task automatic reset_pulse();
      idle_inputs();
      #2 reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
   endtask

   // Cycle 0 is the cycle in which the request is first driven
   task automatic run_one(input vec_t v, output res_t r);
      r = '{ack_cyc: -1, rd_n: 0, wr_n: 0, strobe_cyc: -1, s_addr: 0, s_wdata: 0,
            s_mask: 0, addr_ok: 1, other_ack: 0};
      drive_port(v.port, 1, v.we, v.addr, v.wdata, v.mask);
      for (int k = 0; k < 40 && r.ack_cyc < 0; k++) begin
         bus.mem_stall     = (k >= v.stall_lo) && (k <= v.stall_hi);
         bus.mem_read_data = v.mdata;
         tick();
         if (bus.mem_memread)  r.rd_n++;
         if (bus.mem_memwrite) r.wr_n++;
         if (bus.mem_memread || bus.mem_memwrite) begin
            r.strobe_cyc = k + 1;
            r.s_addr     = bus.mem_addr;
            r.s_wdata    = bus.mem_write_data;
            r.s_mask     = bus.mem_sign_mask;
         end
         if (bus.busy && bus.mem_addr !== v.addr) r.addr_ok = 0;
         if (v.port ? bus.ack0 : bus.ack1) r.other_ack = 1;
         if (v.port ? bus.ack1 : bus.ack0) r.ack_cyc = k + 1;
      end
      drive_port(v.port, 0, 0, 0, 0, 0);
      bus.mem_stall = 0;
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 0, 32'h0000_1004, 32'h0,         4'b0010, 32'hDEAD_BEEF, 99, 0, 5};
      vecs[1] = '{1, 1, 32'h0000_1010, 32'h1234_5678, 4'b0100, 32'hFFFF_FFFF, 99, 0, 5};
      vecs[2] = '{0, 0, 32'h0000_2000, 32'h0,         4'b1111, 32'h0BAD_F00D, 2,  6, 8};
      vecs[3] = '{1, 0, 32'h0000_2004, 32'h0,         4'b0001, 32'hCAFE_F00D, 1,  3, 5};
      vecs[4] = '{0, 1, 32'h0000_3000, 32'hA5A5_A5A5, 4'b1000, 32'h1111_1111, 4,  4, 6};
      vecs[5] = '{1, 0, 32'hFFFF_FFFC, 32'h0,         4'b0011, 32'h7654_3210, 4,  5, 7};

      reset_pulse();
      chk("reset_ctrl", {bus.busy, bus.mem_memread, bus.mem_memwrite, bus.ack0, bus.ack1, bus.grant_id}, 6'd0);
      chk("reset_mem_bus", {bus.mem_addr, bus.mem_write_data, bus.mem_sign_mask}, 68'd0);
      chk("reset_rdata", {bus.rdata0, bus.rdata1}, 64'd0);

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         run_one(vecs[i], res);
         if (!vecs[i].we) exp_rd[vecs[i].port] = vecs[i].mdata;
         chk($sformatf("v%0d_ack_cycle", i), res.ack_cyc, vecs[i].exp_ack);
         chk($sformatf("v%0d_strobe_cycle", i), res.strobe_cyc, 1);
         chk($sformatf("v%0d_memread_count", i), res.rd_n, vecs[i].we ? 0 : 1);
         chk($sformatf("v%0d_memwrite_count", i), res.wr_n, vecs[i].we ? 1 : 0);
         chk($sformatf("v%0d_strobe_addr", i), res.s_addr, vecs[i].addr);
         chk($sformatf("v%0d_strobe_mask", i), res.s_mask, vecs[i].mask);
         if (vecs[i].we) chk($sformatf("v%0d_strobe_wdata", i), res.s_wdata, vecs[i].wdata);
         chk($sformatf("v%0d_addr_stable", i), res.addr_ok, 1);
         chk($sformatf("v%0d_other_ack", i), res.other_ack, 0);
         chk($sformatf("v%0d_rdata0", i), bus.rdata0, exp_rd[0]);
         chk($sformatf("v%0d_rdata1", i), bus.rdata1, exp_rd[1]);
      end

      // Both ports requesting continuously
      reset_pulse();
`ifdef DMEM_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1, 1};
`else
      exp_seq = '{0, 0, 0, 0, 1};
`endif
      nack = 0;
      drive_port(0, 1, 0, 32'h4000, 0, 4'hF);
      drive_port(1, 1, 0, 32'h5000, 0, 4'hF);
      for (int k = 0; k < 200 && nack < 5; k++) begin
         tick();
         if (bus.ack0 || bus.ack1) begin
            gseq[nack] = bus.ack1 ? 1 : 0;
            nack++;
            if (nack == 4) drive_port(0, 0, 0, 0, 0, 0);
         end
      end
      drive_port(1, 0, 0, 0, 0, 0);
      chk("tie_ack_count", nack, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("tie_grant%0d", i), gseq[i], exp_seq[i]);
      tick();
      tick();

      // Reset in the middle of WAIT
      reset_pulse();
      drive_port(0, 1, 0, 32'h3333_0000, 0, 4'h2);
      bus.mem_read_data = 32'h1357_9BDF;
      tick();
      tick();
      tick();
      chk("midreset_busy_before", bus.busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_ctrl", {bus.busy, bus.mem_memread, bus.mem_memwrite, bus.ack0, bus.ack1}, 5'd0);
      chk("midreset_mem_addr", bus.mem_addr, 32'd0);
      drive_port(0, 0, 0, 0, 0, 0);
      tick();
      reset_n = 1'b1;
      chk("midreset_no_ack", {bus.ack0, bus.ack1}, 2'd0);
      run_one(vecs[0], res);
      chk("postreset_ack_cycle", res.ack_cyc, MIN_LAT + 2);
      chk("postreset_rdata0", bus.rdata0, 32'hDEAD_BEEF);

      // MIN_LAT = 1 instance: back-to-back reads on port 0
      nack = 0;
      busm.req0 = 1; busm.we0 = 0; busm.addr0 = 32'h600; busm.mask0 = 4'h1;
      for (int k = 0; k < 40 && nack < 3; k++) begin
         busm.mem_read_data = 32'h5A00_0000 + k;
         tick();
         if (busm.ack0) begin
            acks_m[nack] = k + 1;
            chk($sformatf("minlat1_rdata%0d", nack), busm.rdata0, 32'h5A00_0000 + k);
            nack++;
            busm.addr0 = busm.addr0 + 32'h4;
         end
      end
      busm.req0 = 0;
      chk("minlat1_ack_count", nack, 3);
      chk("minlat1_first_ack", acks_m[0], 3);
      chk("minlat1_spacing1", acks_m[1] - acks_m[0], 4);
      chk("minlat1_spacing2", acks_m[2] - acks_m[1], 4);
      tick();

      // Randomized traffic against a transaction-level model
      reset_pulse();
      act = 0; m_last = 1; pend[0] = 0; pend[1] = 0; a_t = 0; a_ack = -1;
      for (int n = 0; n < 3000; n++) begin
         in_acc   = act && (n >= a_t + 1) && (a_ack < 0 || n <= a_ack);
         exp_ctrl = {in_acc, in_acc && (n == a_t + 1) && !a_we, in_acc && (n == a_t + 1) && a_we,
                     in_acc && (n == a_ack) && !a_port, in_acc && (n == a_ack) && a_port};
         chk("rnd_ctrl", {bus.busy, bus.mem_memread, bus.mem_memwrite, bus.ack0, bus.ack1}, exp_ctrl);
         if (in_acc)
            chk("rnd_bus", {bus.grant_id, bus.mem_addr, bus.mem_write_data, bus.mem_sign_mask},
                {a_port, a_addr, a_wdata, a_mask});
         chk("rnd_rdata0", bus.rdata0, exp_rd[0]);
         chk("rnd_rdata1", bus.rdata1, exp_rd[1]);

         for (int p = 0; p < 2; p++) begin
            if (p == 0 ? bus.ack0 : bus.ack1) pend[p] = 0;
            if (!pend[p] && $urandom_range(3) == 0) begin
               pend[p]    = 1;
               p_we[p]    = $urandom_range(1) == 1;
               p_addr[p]  = $urandom;
               p_wdata[p] = $urandom;
               p_mask[p]  = 4'($urandom);
            end
            drive_port(p[0], pend[p], p_we[p], p_addr[p], p_wdata[p], p_mask[p]);
         end
         stall_now         = $urandom_range(2) == 0;
         rd_now            = $urandom;
         bus.mem_stall     = stall_now;
         bus.mem_read_data = rd_now;

         if (act && a_ack >= 0 && n > a_ack) act = 0;
         if (!act) begin
            if (pend[0] || pend[1]) begin
`ifdef DMEM_ARB_RR_EN
               win = (pend[0] && pend[1]) ? ~m_last : pend[1];
`else
               win = !pend[0];
`endif
               act = 1; a_t = n; a_ack = -1; a_port = win;
               a_we = p_we[win]; a_addr = p_addr[win]; a_wdata = p_wdata[win]; a_mask = p_mask[win];
            end
         end else if (a_ack < 0 && n >= a_t + MIN_LAT + 1 && !stall_now) begin
            a_ack = n + 1;
            if (!a_we) exp_rd[a_port] = rd_now;
            m_last = a_port;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
